regfile_wb_controller: RTL and testbench
========================================

# regfile_wb_controller

Write-back controller for the 32x32 register file's single clocked write port. It arbitrates between two write-back requesters, the ALU and the load/store unit, with round-robin on ties. It registers the granted write onto the register-file port. It also keeps a per-register pending-write scoreboard so the issue stage can interlock on rs1/rs2 until an outstanding load result has been written.

## Interface
Parameters:
- XLEN, 32, data width of a write-back.
- REG_AW, 5, register address width (2**REG_AW registers; register 0 hard-wired zero).

Ports:
- clock  in  1  rising-edge clock, shared with the register file.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  REG_AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU write-back request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_rd  in  REG_AW  LSU destination register.
- lsu_data  in  XLEN  load result.
- rsv_valid  in  1  issue stage reserves rsv_rd (load issued).
- rsv_rd  in  REG_AW  register to mark pending.
- rs1, rs2  in  REG_AW  source registers under check.
- rs1_busy, rs2_busy  out  1  source has a pending write.
- fwd1_hit, fwd2_hit  out  1  same-cycle forward valid (see Configuration).
- fwd1_data, fwd2_data  out  XLEN  forwarded value.
- rf_writereg  out  REG_AW  to register file writereg.
- rf_writedata  out  XLEN  to register file writedata.
- rf_inEn  out  1  to register file inEn.

Clock is `clock`. Reset is asynchronous and active-low on `reset_n`.

## Operation
- Accept means valid && ready in the same cycle. The requester holds rd and data stable while valid is high and ready is low.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the requester not granted most recently, tracked in a last_grant flag (ALU or LSU).
  - last_grant updates on every accept.
- ready is combinational from the valids and last_grant. A requester whose valid is low still sees ready high when it would win, i.e. ready does not depend on its own valid.
- The output stage drains every cycle; there is no other backpressure.
- An accepted request with rd == 0 is consumed and updates last_grant, but leaves rf_inEn low.
- Scoreboard: busy[2**REG_AW] bits.
  - Set busy[rsv_rd] on rsv_valid when rsv_rd != 0.
  - Clear busy[rf_writereg] at the clock edge ending a cycle with rf_inEn high.
  - Set and clear of the same register in the same cycle: set wins, because it is a newer reservation.
- rsX_busy = busy[rsX], combinational. It is always 0 for rsX == 0.
- ALU writes to a busy register are legal. They clear busy, because ALU write-backs never reserve.

## Timing
- Reset values: alu_ready/lsu_ready follow the valids combinationally; all other outputs, all busy bits, rf_inEn, rf_writereg and rf_writedata are 0; last_grant = LSU, so the ALU wins the first tie.
- Latency: accept in cycle N, then rf_inEn, rf_writereg and rf_writedata are valid throughout cycle N+1. The register file commits at the edge ending N+1.
- Throughput is one write per cycle. Back-to-back accepts produce back-to-back rf_inEn.
- Reset asserted mid-operation: the pending output-stage write is dropped and every busy bit clears immediately.
- rsv_valid in cycle N: rsX_busy is high from cycle N+1.

## Configuration
- WB_FORWARD_EN defined: in a cycle with rf_inEn high and rf_writereg == rsX != 0:
  - fwdX_hit = 1 and fwdX_data = rf_writedata.
  - rsX_busy is forced 0 that cycle.
- WB_FORWARD_EN undefined: the fwd ports are present but tied to 0, and rsX_busy reflects the busy bit only.

## Structure
- Shared package riscv_pkg holds XLEN, REG_AW and the grant_t enum {GRANT_ALU, GRANT_LSU}.
- One sub-module, rr_arbiter2: a two-requester round-robin arbiter that owns last_grant and produces the grants.
- Scoreboard, output register and forwarding logic live in regfile_wb_controller.

## Test plan
- Reset, then ALU alone with rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle rf_inEn=1, rf_writereg=5, rf_writedata=0xDEADBEEF.
- ALU and LSU both held valid for 4 cycles -> grants alternate ALU, LSU, ALU, LSU, and rf_inEn stays high for 4 consecutive cycles.
- LSU request with rd=0, data=0x1234 -> lsu_ready=1, rf_inEn stays 0, and the next tie goes to the ALU.
- rsv_valid with rsv_rd=7, then rs1=7 -> rs1_busy=1 until the LSU write to 7 is delivered, and 0 the cycle after.
  - With WB_FORWARD_EN: fwd1_hit=1 and rs1_busy=0 in the delivery cycle.
- rsv_valid with rsv_rd=9 in the same cycle rf_inEn writes 9 -> busy[9] stays 1.
- Assert reset_n low in the cycle after an accept -> rf_inEn=0 immediately and all busy bits are 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the register-file write-back path.
//   XLEN    - data width of a write-back
//   REG_AW  - register address width (2**REG_AW registers, x0 hard-wired zero)
//   grant_t - identifies which write-back requester was granted last
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_t;

endpackage : riscv_pkg

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter for the write-back port.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   alu_valid  in   ALU requests the write port
//   lsu_valid  in   LSU requests the write port
//   alu_ready  out  ALU would win / wins this cycle (independent of alu_valid)
//   lsu_ready  out  LSU would win / wins this cycle (independent of lsu_valid)
//   alu_accept out  ALU request accepted this cycle (valid && ready)
//   lsu_accept out  LSU request accepted this cycle (valid && ready)
//
// A lone requester always wins. On a tie the requester that was not granted
// most recently wins. After reset last_grant is LSU, so the ALU wins the
// first tie.
module rr_arbiter2 (
  input  logic clock,
  input  logic reset_n,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_ready,
  output logic lsu_ready,
  output logic alu_accept,
  output logic lsu_accept
);

  import riscv_pkg::*;

  grant_t last_grant;

  // Each ready looks only at the other requester's valid, so a requester
  // sees ready before it raises valid whenever it would win.
  always_comb begin
    alu_ready  = !lsu_valid || (last_grant == GRANT_LSU);
    lsu_ready  = !alu_valid || (last_grant == GRANT_ALU);
    alu_accept = alu_valid && alu_ready;
    lsu_accept = lsu_valid && lsu_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_LSU;
    end else if (alu_accept) begin
      last_grant <= GRANT_ALU;
    end else if (lsu_accept) begin
      last_grant <= GRANT_LSU;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_controller.sv
// regfile_wb_controller: write-back controller for the register file's
// single clocked write port.
//
// Arbitrates ALU and LSU write-back requests (round-robin on ties), registers
// the granted write onto the register-file port, and keeps a per-register
// pending-write scoreboard used by the issue stage to interlock on rs1/rs2.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   - when the registered write targets rsX (rsX != 0), fwdX_hit is
//               raised with fwdX_data = rf_writedata and rsX_busy is masked.
//   undefined - fwd ports are tied to 0; rsX_busy is the scoreboard bit only.
//
// Ports:
//   clock, reset_n              clock / asynchronous active-low reset
//   alu_valid/ready/rd/data     ALU write-back request handshake
//   lsu_valid/ready/rd/data     LSU write-back request handshake
//   rsv_valid, rsv_rd           issue stage marks rsv_rd pending (load issued)
//   rs1, rs2                    source registers under check
//   rs1_busy, rs2_busy          source has a pending write
//   fwd1_hit/data, fwd2_hit/data  same-cycle forward of the outgoing write
//   rf_writereg/writedata/inEn  register-file write port
module regfile_wb_controller #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              rsv_valid,
  input  logic [REG_AW-1:0] rsv_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data,
  output logic [REG_AW-1:0] rf_writereg,
  output logic [XLEN-1:0]   rf_writedata,
  output logic              rf_inEn
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic                alu_accept;
  logic                lsu_accept;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  rr_arbiter2 u_arbiter (
    .clock      (clock),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .lsu_valid  (lsu_valid),
    .alu_ready  (alu_ready),
    .lsu_ready  (lsu_ready),
    .alu_accept (alu_accept),
    .lsu_accept (lsu_accept)
  );

  // Output stage: drains every cycle. A write to x0 is consumed by the
  // arbiter but never enables the register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_inEn      <= 1'b0;
      rf_writereg  <= '0;
      rf_writedata <= '0;
    end else if (alu_accept) begin
      rf_inEn      <= (alu_rd != '0);
      rf_writereg  <= alu_rd;
      rf_writedata <= alu_data;
    end else if (lsu_accept) begin
      rf_inEn      <= (lsu_rd != '0);
      rf_writereg  <= lsu_rd;
      rf_writedata <= lsu_data;
    end else begin
      rf_inEn      <= 1'b0;
    end
  end

  // Scoreboard next state. The write leaving the output stage clears its bit;
  // a reservation in the same cycle is applied afterwards so the newer
  // reservation wins. Register 0 never becomes busy.
  // NOTE: every always_comb output gets a full default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (rf_inEn) begin
      busy_next[rf_writereg] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != '0)) begin
      busy_next[rsv_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: the scoreboard is a plain flop vector, not a memory, so it is reset
  // asynchronously; a reset mid-operation clears every pending mark at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Interlock and forwarding.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
`ifdef WB_FORWARD_EN
    // The outgoing write satisfies a reader in the cycle it is delivered.
    fwd1_hit  = rf_inEn && (rf_writereg == rs1) && (rs1 != '0);
    fwd2_hit  = rf_inEn && (rf_writereg == rs2) && (rs2 != '0);
    fwd1_data = fwd1_hit ? rf_writedata : '0;
    fwd2_data = fwd2_hit ? rf_writedata : '0;
`endif
    rs1_busy  = busy[rs1] && (rs1 != '0) && !fwd1_hit;
    rs2_busy  = busy[rs2] && (rs2 != '0) && !fwd2_hit;
  end

endmodule : regfile_wb_controller

// File: tb/tb_regfile_wb_controller.sv
// Testbench for regfile_wb_controller: directed stimulus, a behavioural
// model of the write-back rules, a per-cycle compare process and a set of
// hand-computed literal checks.
module tb_regfile_wb_controller;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              alu_valid, lsu_valid, rsv_valid;
  logic              alu_ready, lsu_ready;
  logic [REG_AW-1:0] alu_rd, lsu_rd, rsv_rd, rs1, rs2;
  logic [XLEN-1:0]   alu_data, lsu_data;
  logic              rs1_busy, rs2_busy, fwd1_hit, fwd2_hit;
  logic [XLEN-1:0]   fwd1_data, fwd2_data;
  logic [REG_AW-1:0] rf_writereg;
  logic [XLEN-1:0]   rf_writedata;
  logic              rf_inEn;

  regfile_wb_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .rsv_valid    (rsv_valid),
    .rsv_rd       (rsv_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .fwd1_hit     (fwd1_hit),
    .fwd2_hit     (fwd2_hit),
    .fwd1_data    (fwd1_data),
    .fwd2_data    (fwd2_data),
    .rf_writereg  (rf_writereg),
    .rf_writedata (rf_writedata),
    .rf_inEn      (rf_inEn)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_last_was_lsu;   // who was granted most recently
  bit              m_pend;           // a register-file write is due this cycle
  int              m_pend_rd;
  logic [XLEN-1:0] m_pend_data;
  bit              m_busy [NREGS];
  string           grant_log;        // "A"/"L" per accept, for literal checks

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_last_was_lsu = 1'b1;
      m_pend         = 1'b0;
      m_pend_rd      = 0;
      m_pend_data    = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      bit alu_wins, lsu_wins;
      alu_wins = alu_valid && (!lsu_valid || m_last_was_lsu);
      lsu_wins = lsu_valid && !alu_wins;
      // write delivered now retires its mark, then new reservation applies
      if (m_pend) m_busy[m_pend_rd] = 1'b0;
      if (rsv_valid && rsv_rd != 0) m_busy[int'(rsv_rd)] = 1'b1;
      m_pend = 1'b0;
      if (alu_wins) begin
        m_pend = (alu_rd != 0); m_pend_rd = int'(alu_rd); m_pend_data = alu_data;
        m_last_was_lsu = 1'b0; grant_log = {grant_log, "A"};
      end else if (lsu_wins) begin
        m_pend = (lsu_rd != 0); m_pend_rd = int'(lsu_rd); m_pend_data = lsu_data;
        m_last_was_lsu = 1'b1; grant_log = {grant_log, "L"};
      end
    end
  end

  function automatic bit exp_fwd(input logic [REG_AW-1:0] rs);
    return FWD && m_pend && rs != 0 && m_pend_rd == int'(rs);
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      check("alu_ready", 64'(alu_ready), 64'(!lsu_valid || m_last_was_lsu));
      check("lsu_ready", 64'(lsu_ready), 64'(!alu_valid || !m_last_was_lsu));
      check("rf_inEn", 64'(rf_inEn), 64'(m_pend));
      if (m_pend) begin
        check("rf_writereg", 64'(rf_writereg), 64'(m_pend_rd));
        check("rf_writedata", 64'(rf_writedata), 64'(m_pend_data));
      end
      check("rs1_busy", 64'(rs1_busy), 64'(rs1 != 0 && m_busy[int'(rs1)] && !exp_fwd(rs1)));
      check("rs2_busy", 64'(rs2_busy), 64'(rs2 != 0 && m_busy[int'(rs2)] && !exp_fwd(rs2)));
      check("fwd1_hit", 64'(fwd1_hit), 64'(exp_fwd(rs1)));
      check("fwd2_hit", 64'(fwd2_hit), 64'(exp_fwd(rs2)));
      if (exp_fwd(rs1)) check("fwd1_data", 64'(fwd1_data), 64'(m_pend_data));
      if (exp_fwd(rs2)) check("fwd2_data", 64'(fwd2_data), 64'(m_pend_data));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 0; lsu_valid = 0; rsv_valid = 0;
    alu_rd = 0; lsu_rd = 0; rsv_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = 0; lsu_data = 0;
    grant_log = "";
    cmp_en = 1'b1;
    tick(); tick();
    // reset state
    check("rst_inEn", 64'(rf_inEn), 64'd0);
    check("rst_writereg", 64'(rf_writereg), 64'd0);
    check("rst_writedata", 64'(rf_writedata), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    reset_n = 1'b1;
    tick();

    // ALU alone, rd=5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 check("t1_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 0;
    check("t1_inEn", 64'(rf_inEn), 64'd1);
    check("t1_writereg", 64'(rf_writereg), 64'd5);
    check("t1_writedata", 64'(rf_writedata), 64'hDEADBEEF);
    tick();

    // LSU write to x0: consumed, no rf write, next tie to ALU
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    #1 check("t3_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 0;
    check("t3_inEn", 64'(rf_inEn), 64'd0);

    // Tie for 4 cycles: ALU, LSU, ALU, LSU
    grant_log = "";
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_inEn", 64'(rf_inEn), 64'd1);
      check("t2_writereg", 64'(rf_writereg), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    alu_valid = 0; lsu_valid = 0;
    check("t2_order", (grant_log == "ALAL") ? 64'd1 : 64'd0, 64'd1);
    tick();
    check("t2_drain", 64'(rf_inEn), 64'd0);

    // Reserve 7, LSU load result delivered later
    rsv_valid = 1; rsv_rd = 7; rs1 = 7;
    tick();
    rsv_valid = 0;
    check("t4_busy_n1", 64'(rs1_busy), 64'd1);
    tick();
    check("t4_busy_n2", 64'(rs1_busy), 64'd1);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_0777;
    tick();
    lsu_valid = 0;
    check("t4_deliver", 64'(rf_inEn), 64'd1);
    check("t4_busy_deliv", 64'(rs1_busy), FWD ? 64'd0 : 64'd1);
    check("t4_fwd_hit", 64'(fwd1_hit), FWD ? 64'd1 : 64'd0);
    tick();
    check("t4_busy_after", 64'(rs1_busy), 64'd0);

    // Reserve 9; ALU write to 9 delivered in the same cycle as a new reservation
    rsv_valid = 1; rsv_rd = 9; rs2 = 9;
    tick();
    rsv_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    rsv_valid = 1; rsv_rd = 9;
    tick();
    rsv_valid = 0;
    check("t5_set_wins", 64'(rs2_busy), 64'd1);

    // Reservation of x0 is ignored; rs=0 never busy
    rsv_valid = 1; rsv_rd = 0; rs1 = 0;
    tick();
    rsv_valid = 0;
    check("x0_busy", 64'(rs1_busy), 64'd0);

    // Reset mid-operation: drop pending write, clear busy bits
    rsv_valid = 1; rsv_rd = 11; rs1 = 11;
    tick();
    rsv_valid = 0;
    alu_valid = 1; alu_rd = 12; alu_data = 32'hC0FFEE;
    tick();
    alu_valid = 0;
    check("t6_pre_inEn", 64'(rf_inEn), 64'd1);
    check("t6_pre_busy", 64'(rs1_busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_inEn", 64'(rf_inEn), 64'd0);
    check("t6_busy1", 64'(rs1_busy), 64'd0);
    check("t6_busy2", 64'(rs2_busy), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // After reset the ALU wins the first tie
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    #1;
    check("t7_alu_ready", 64'(alu_ready), 64'd1);
    check("t7_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    alu_valid = 0;
    check("t7_writereg", 64'(rf_writereg), 64'd3);
    tick();
    lsu_valid = 0;
    check("t7_lsu_after", 64'(rf_writereg), 64'd4);
    tick(); tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_controller
